// File: rtl/sorted_array_reader_if.sv
// Streaming output channel of the sorted-array reader: one word per valid/ready
// handshake, with a marker on the final word of a read-out.
interface sorted_array_reader_if #(
    parameter int k = 32
) ();
    logic [k-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sorted_array_reader.sv
// Walks an N-entry register file through its read port, streams the words out
// lowest address first, and flags any word that is smaller than its predecessor.
module sorted_array_reader #(
    parameter int k  = 32,
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [AW-1:0]          rd_addr,
    input  logic [k-1:0]           rd_data,
    sorted_array_reader_if.master  stream,
    output logic                   busy,
    output logic                   done,
    output logic                   order_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] rd_addr_r;
    logic [k-1:0]  data_r;
    logic          valid_r;
    logic          last_r;
    logic          busy_r;
    logic          done_r;
    logic          order_err_r;

    logic [AW-1:0] idx_inc_s;
    logic          handshake_s;

    // Address presented while word i is on the output: prefetch i+1, park at 0 after the last.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] i);
        logic [AW-1:0] a;
        if (i < LAST_IDX) begin
            a = i + AW'(1);
        end else begin
            a = ZERO_IDX;
        end
        return a;
    endfunction

    assign idx_inc_s   = idx_r + AW'(1);
    assign handshake_s = valid_r & stream.out_ready;

    // Read-out sequencer; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= ZERO_IDX;
            rd_addr_r   <= ZERO_IDX;
            data_r      <= {k{1'b0}};
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            order_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_FETCH;
                        idx_r       <= ZERO_IDX;
                        rd_addr_r   <= ZERO_IDX;
                        order_err_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    data_r    <= rd_data;
                    valid_r   <= 1'b1;
                    last_r    <= (LAST_IDX == ZERO_IDX);
                    rd_addr_r <= next_addr(ZERO_IDX);
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake_s) begin
                        if (idx_r < LAST_IDX) begin
                            // rd_data already holds word idx+1, so the next word loads without a bubble.
                            data_r    <= rd_data;
                            idx_r     <= idx_inc_s;
                            last_r    <= (idx_inc_s == LAST_IDX);
                            rd_addr_r <= next_addr(idx_inc_s);
                            if (rd_data < data_r) begin
                                order_err_r <= 1'b1;
                            end
                        end else begin
                            valid_r   <= 1'b0;
                            last_r    <= 1'b0;
                            rd_addr_r <= ZERO_IDX;
                            done_r    <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= ZERO_IDX;
                    rd_addr_r <= ZERO_IDX;
                    valid_r   <= 1'b0;
                    last_r    <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr          = rd_addr_r;
    assign stream.out_data  = data_r;
    assign stream.out_valid = valid_r;
    assign stream.out_last  = last_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign order_err        = order_err_r;

endmodule

// File: tb/tb_sorted_array_reader.sv
// Scoreboard bench for sorted_array_reader: N=8, N=1 and N=2 instances, each
// reading a bench-owned memory; expected words queue at start, pop on handshake.
module tb_sorted_array_reader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        start8 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [2:0]  rd_addr8;
    logic [0:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data8, rd_data1, rd_data2;
    logic [31:0] mem8 [8];
    logic [31:0] mem1 [1];
    logic [31:0] mem2 [2];
    logic        busy8, done8, err8, busy1, done1, err1, busy2, done2, err2;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] sb [$];

    sorted_array_reader_if #(.k(32)) s8 ();
    sorted_array_reader_if #(.k(32)) s1 ();
    sorted_array_reader_if #(.k(32)) s2 ();

    assign rd_data8 = mem8[rd_addr8];
    assign rd_data1 = (rd_addr1 == 1'b0) ? mem1[0] : 32'hDEAD_BEEF;
    assign rd_data2 = mem2[rd_addr2];

    sorted_array_reader #(.k(32), .N(8), .AW(3)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .stream(s8), .busy(busy8), .done(done8), .order_err(err8));
    sorted_array_reader #(.k(32), .N(1), .AW(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .stream(s1), .busy(busy1), .done(done1), .order_err(err1));
    sorted_array_reader #(.k(32), .N(2), .AW(1)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .stream(s2), .busy(busy2), .done(done2), .order_err(err2));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_sorted();
        mem8[0] = 32'd1; mem8[1] = 32'd2; mem8[2] = 32'd3;  mem8[3] = 32'd5;
        mem8[4] = 32'd5; mem8[5] = 32'd8; mem8[6] = 32'd13; mem8[7] = 32'd21;
    endtask

    task automatic load_unsorted();
        mem8[0] = 32'd1; mem8[1] = 32'd2; mem8[2] = 32'd9; mem8[3] = 32'd4;
        mem8[4] = 32'd5; mem8[5] = 32'd6; mem8[6] = 32'd7; mem8[7] = 32'd8;
    endtask

    // Full N=8 read-out: start at edge 0, then consume with optional 1,0,0 backpressure.
    task automatic run_stream8(input bit bp, input bit exp_err, input int err_word,
                               input int pulse_cyc, input string tag);
        int cyc, lows, vcount, first_v, done_cyc, w;
        logic [31:0] exp_w, prev_data;
        logic want;
        bit stalled;
        for (int i = 0; i < 8; i++) sb.push_back(mem8[i]);
        s8.out_ready = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 1; lows = 0; vcount = 0; first_v = -1; done_cyc = -1; stalled = 1'b0;
        tests_run++;
        if (busy8 !== 1'b1 || s8.out_valid !== 1'b0 || err8 !== 1'b0) begin
            fails++;
            $display("FAIL %s_fetch: busy=%b valid=%b err=%b, want 1 0 0", tag, busy8, s8.out_valid, err8);
        end
        while (cyc < 200) begin
            start8 = (cyc == pulse_cyc);
            if (done8 === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (s8.out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                w = 8 - sb.size();
                s8.out_ready = bp ? ((vcount % 3) == 0) : 1'b1;
                vcount++;
                if (stalled) begin
                    tests_run++;
                    if (s8.out_data !== prev_data) begin
                        fails++;
                        $display("FAIL %s_stable: data=%h want %h", tag, s8.out_data, prev_data);
                    end
                end
                want = (w == 7);
                tests_run++;
                if (s8.out_last !== want) begin
                    fails++;
                    $display("FAIL %s_last: word %0d last=%b want %b", tag, w, s8.out_last, want);
                end
                want = exp_err && (w >= err_word);
                tests_run++;
                if (err8 !== want) begin
                    fails++;
                    $display("FAIL %s_order_err: word %0d err=%b want %b", tag, w, err8, want);
                end
                if (s8.out_ready) begin
                    tests_run++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL %s_extra: unexpected word %h", tag, s8.out_data);
                    end else begin
                        exp_w = sb.pop_front();
                        if (s8.out_data !== exp_w) begin
                            fails++;
                            $display("FAIL %s_data: word %0d got %h want %h", tag, w, s8.out_data, exp_w);
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    lows++;
                    stalled = 1'b1;
                    prev_data = s8.out_data;
                end
            end
            tick();
            cyc++;
        end
        start8 = 1'b0;
        s8.out_ready = 1'b1;
        tests_run++;
        if (first_v != 2) begin
            fails++;
            $display("FAIL %s_first_cycle: got %0d want 2", tag, first_v);
        end
        tests_run++;
        if (done_cyc != 10 + lows) begin
            fails++;
            $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_cyc, 10 + lows);
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_lost: %0d words never streamed", tag, sb.size());
            sb.delete();
        end
        tick();
        tests_run++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || err8 !== exp_err) begin
            fails++;
            $display("FAIL %s_idle: done=%b busy=%b err=%b want 0 0 %b", tag, done8, busy8, err8, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start8 = 1'b1;
        tick(); tick();
        tests_run++;
        if ({busy8, done8, err8, s8.out_valid, s8.out_last} !== 5'b0 || s8.out_data !== 32'd0 || rd_addr8 !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b err=%b valid=%b last=%b data=%h addr=%0d, want all 0",
                     busy8, done8, err8, s8.out_valid, s8.out_last, s8.out_data, rd_addr8);
        end
        reset = 1'b0;
        start8 = 1'b0;
        tick();
    endtask

    task automatic test_sorted();
        load_sorted();
        run_stream8(1'b0, 1'b0, 0, -1, "sorted");
    endtask

    task automatic test_unsorted();
        load_unsorted();
        run_stream8(1'b0, 1'b1, 3, -1, "unsorted");
        load_sorted();
        run_stream8(1'b0, 1'b0, 0, -1, "clear_on_start");
    endtask

    task automatic test_backpressure();
        load_sorted();
        mem8[2] = 32'd4; mem8[5] = 32'd9;
        run_stream8(1'b1, 1'b0, 0, -1, "backpressure");
    endtask

    task automatic test_ignored_start();
        load_unsorted();
        run_stream8(1'b0, 1'b1, 3, 6, "ignored_start");
    endtask

    task automatic test_reset_midstream();
        load_unsorted();
        s8.out_ready = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        tests_run++;
        if (s8.out_valid !== 1'b1 || s8.out_data !== mem8[3] || err8 !== 1'b1) begin
            fails++;
            $display("FAIL midrst_word3: valid=%b data=%h err=%b want 1 %h 1", s8.out_valid, s8.out_data, err8, mem8[3]);
        end
        reset = 1'b1;
        start8 = 1'b1;
        tick();
        reset = 1'b0;
        start8 = 1'b0;
        tests_run++;
        if ({busy8, done8, err8, s8.out_valid, s8.out_last} !== 5'b0 || s8.out_data !== 32'd0 || rd_addr8 !== 3'd0) begin
            fails++;
            $display("FAIL midrst_clear: busy=%b done=%b err=%b valid=%b last=%b data=%h addr=%0d, want all 0",
                     busy8, done8, err8, s8.out_valid, s8.out_last, s8.out_data, rd_addr8);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_done: done=%b busy=%b want 0 0", done8, busy8);
            end
        end
        load_sorted();
        run_stream8(1'b0, 1'b0, 0, -1, "after_reset");
    endtask

    task automatic test_n1();
        logic [31:0] exp_w;
        mem1[0] = 32'hFFFF_FFFF;
        sb.push_back(mem1[0]);
        s1.out_ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tests_run++;
        if (busy1 !== 1'b1 || s1.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL n1_fetch: busy=%b valid=%b want 1 0", busy1, s1.out_valid);
        end
        tick();
        exp_w = sb.pop_front();
        tests_run++;
        if (s1.out_valid !== 1'b1 || s1.out_last !== 1'b1 || s1.out_data !== exp_w) begin
            fails++;
            $display("FAIL n1_word: valid=%b last=%b data=%h want 1 1 %h", s1.out_valid, s1.out_last, s1.out_data, exp_w);
        end
        tick();
        tests_run++;
        if (done1 !== 1'b1 || s1.out_valid !== 1'b0 || err1 !== 1'b0) begin
            fails++;
            $display("FAIL n1_done: done=%b valid=%b err=%b want 1 0 0", done1, s1.out_valid, err1);
        end
        tick();
        tests_run++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL n1_idle: done=%b busy=%b want 0 0", done1, busy1);
        end
    endtask

    task automatic test_n2_unsigned();
        logic [31:0] exp_w;
        mem2[0] = 32'hFFFF_FFFF;
        mem2[1] = 32'h0000_0000;
        sb.push_back(mem2[0]);
        sb.push_back(mem2[1]);
        s2.out_ready = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        exp_w = sb.pop_front();
        tests_run++;
        if (s2.out_valid !== 1'b1 || s2.out_last !== 1'b0 || s2.out_data !== exp_w || err2 !== 1'b0) begin
            fails++;
            $display("FAIL n2_word0: valid=%b last=%b data=%h err=%b want 1 0 %h 0",
                     s2.out_valid, s2.out_last, s2.out_data, err2, exp_w);
        end
        tick();
        exp_w = sb.pop_front();
        tests_run++;
        if (s2.out_valid !== 1'b1 || s2.out_last !== 1'b1 || s2.out_data !== exp_w || err2 !== 1'b1) begin
            fails++;
            $display("FAIL n2_word1: valid=%b last=%b data=%h err=%b want 1 1 %h 1",
                     s2.out_valid, s2.out_last, s2.out_data, err2, exp_w);
        end
        tick();
        tests_run++;
        if (done2 !== 1'b1 || err2 !== 1'b1) begin
            fails++;
            $display("FAIL n2_done: done=%b err=%b want 1 1", done2, err2);
        end
        tick();
        tests_run++;
        if (busy2 !== 1'b0 || err2 !== 1'b1) begin
            fails++;
            $display("FAIL n2_idle: busy=%b err=%b want 0 1", busy2, err2);
        end
    endtask

    initial begin
        s8.out_ready = 1'b1;
        s1.out_ready = 1'b1;
        s2.out_ready = 1'b1;
        load_sorted();
        mem1[0] = 32'd0;
        mem2[0] = 32'd0;
        mem2[1] = 32'd0;
        test_reset();
        test_sorted();
        test_unsorted();
        test_backpressure();
        test_ignored_start();
        test_reset_midstream();
        test_n1();
        test_n2_unsigned();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sorted_array_reader.md
# sorted_array_reader

Read-side counterpart of the bubble-sort register array. After a sort pass completes, it walks the N-entry register file through its read-address/read-data port and streams every word out over a valid/ready interface, lowest address first. While streaming it checks that each word is unsigned ≥ its predecessor and flags any ordering violation, giving the datapath a built-in sortedness check.

## Interface
Parameters:
- `k`, 32, data word width
- `N`, 8, number of register-file entries to read (N ≥ 1)
- `AW`, 3, address width; N ≤ 2^AW required

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a read-out; accepted only in IDLE
- `rd_addr`  out  AW  read address to register-file output mux
- `rd_data`  in  k  read data; combinational function of `rd_addr`, valid same cycle
- `out_data`  out  k  streamed word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts word when high with `out_valid`
- `out_last`  out  1  high with `out_valid` on word index N-1
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse after last word accepted
- `order_err`  out  1  sticky: a word < its predecessor was read; cleared on accepted `start`

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: `busy`=0, `out_valid`=0, `rd_addr`=0. `start`=1 → FETCH; `idx`←0; `order_err`←0.
- FETCH: `rd_addr`=0. Capture `rd_data` into `out_data`; `out_valid`←1; → SEND.
- SEND: `rd_addr`=`idx`+1 when `idx`<N-1, else 0. `out_data`/`out_last` held stable while `out_valid`=1 and `out_ready`=0.
  - Handshake (`out_valid`&`out_ready`) with `idx`<N-1: `out_data`←`rd_data`, `idx`←`idx`+1, `out_valid` stays 1 (no bubble); stay in SEND.
  - Handshake with `idx`=N-1: `out_valid`←0 → DONE.
- DONE: `done`=1 for this cycle only → IDLE.
- Order check: on each in-SEND capture, if `rd_data` < current `out_data` (unsigned, full k bits) then `order_err`←1. Equal values are legal. Never cleared except by reset or accepted `start`; remains readable in IDLE.
- `out_last` = (`idx`=N-1) & `out_valid`.
- `start` outside IDLE ignored (no restart, no `order_err` clear).
- N=1: FETCH loads word 0 with `out_last`=1; handshake → DONE; order check never fires.
- `idx` never wraps; `rd_addr` never exceeds N-1.

## Timing
- Reset (any state, including mid-stream): next cycle state=IDLE, `idx`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `order_err`=0, `rd_addr`=0; no `done` pulse for an aborted read-out. Reset dominates `start` in the same cycle.
- `start` sampled at edge t → FETCH during cycle t+1 (`busy`=1), first word valid in cycle t+2.
- With `out_ready` held 1: words 0..N-1 in cycles t+2..t+N+1, `done` in cycle t+N+2, IDLE (`busy`=0) in t+N+3; a new `start` accepted at end of t+N+3.
- Throughput 1 word/cycle; each `out_ready` low cycle adds exactly one cycle.
- `out_valid` never deasserts before handshake; `out_data` changes only on handshake or FETCH.
- `order_err` updates at the same edge that captures the offending word; visible when that word is valid.

## Test plan
- Sorted stream: N=8, memory {1,2,3,5,5,8,13,21}, `out_ready`=1, `start` at edge 0 → words in cycles 2..9 in order, `out_last` only at cycle 9, `done` at cycle 10, `order_err`=0.
- Unsorted: memory {1,2,9,4,5,6,7,8} → `order_err` rises with word 4 valid (cycle 5), remains 1 through IDLE; next `start` clears it.
- Backpressure: `out_ready` toggles 1,0,0,1,… → `out_data` stable across low cycles, no word lost or duplicated, total cycles = 8 + number of low cycles + 3.
- Reset mid-stream: assert `reset` while word 3 valid → next cycle all outputs 0, IDLE, no `done`; subsequent `start` streams from word 0.
- Ignored start / boundaries: `start` pulsed in SEND has no effect; N=1 with memory {0xFFFFFFFF} → single word with `out_last`=1, `done` one cycle later; unsigned compare {0xFFFFFFFF,0x00000000} at N=2 sets `order_err`.
